// File: rtl/regfile_sb_if.sv
// Bundle of the write-back, PC, operand read and scoreboard signals of regfile_sb.
// The master is the sequencer and datapath side, and the slave is the register file.
interface regfile_sb_if #(
  parameter int W  = 16,
  parameter int AW = 3
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wd;
  logic          pc_we;
  logic [W-1:0]  pc_d;
  logic          pc_inc;
  logic          ra_en;
  logic [AW-1:0] ra_addr;
  logic [W-1:0]  qa;
  logic          rb_en;
  logic [AW-1:0] rb_addr;
  logic [W-1:0]  qb;
  logic          sb_set;
  logic [AW-1:0] sb_addr;
  logic          busy_a;
  logic          busy_b;
  logic          stall;
  logic          sb_err;
  logic [W-1:0]  pc;

  modport master (
    output we, waddr, wd, pc_we, pc_d, pc_inc,
    output ra_en, ra_addr, rb_en, rb_addr, sb_set, sb_addr,
    input  qa, qb, busy_a, busy_b, stall, sb_err, pc
  );

  modport slave (
    input  we, waddr, wd, pc_we, pc_d, pc_inc,
    input  ra_en, ra_addr, rb_en, rb_addr, sb_set, sb_addr,
    output qa, qb, busy_a, busy_b, stall, sb_err, pc
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two bypassed read ports, one write-back port, a PC held in the top
// register, and a per-register pending scoreboard for read-after-write stalls.
module regfile_sb #(
  parameter int          W        = 16,
  parameter int          NREG     = 8,
  parameter int          AW       = 3,
  parameter int unsigned PC_STEP  = 2,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input logic         CLK,
  input logic         RST_N,
  regfile_sb_if.slave bus
);
  localparam int            PC_IDX  = NREG - 1;
  localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);
  localparam logic [W-1:0]  STEP    = W'(PC_STEP);

  logic [W-1:0]    regs [NREG];
  logic [NREG-1:0] pending;
  logic            sb_err_q;

  logic wb_pc;
  logic wb_hits_a;
  logic wb_hits_b;
  logic wb_hits_sb;

  assign wb_pc      = bus.we && (bus.waddr == PC_ADDR);
  assign wb_hits_a  = bus.we && (bus.waddr == bus.ra_addr);
  assign wb_hits_b  = bus.we && (bus.waddr == bus.rb_addr);
  assign wb_hits_sb = bus.we && (bus.waddr == bus.sb_addr);

  // NOTE: every state element uses <= so that all updates read pre-edge values; the
  // array is reset element by element because a reset state is architecturally visible.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG - 1; i++) regs[i] <= '0;
      regs[PC_IDX] <= RESET_PC;
      pending      <= '0;
      sb_err_q     <= 1'b0;
    end else begin
      if (bus.we) regs[bus.waddr] <= bus.wd;

      // Write-back to the PC index beats a PC load, which beats an increment.
      if (!wb_pc) begin
        if (bus.pc_we)       regs[PC_IDX] <= bus.pc_d;
        else if (bus.pc_inc) regs[PC_IDX] <= regs[PC_IDX] + STEP;
      end

      // The set is placed after the clear so a same-cycle collision leaves the bit pending.
      if (bus.we)     pending[bus.waddr]   <= 1'b0;
      if (bus.sb_set) pending[bus.sb_addr] <= 1'b1;

      if (bus.sb_set && pending[bus.sb_addr] && !wb_hits_sb) sb_err_q <= 1'b1;
    end
  end

  logic [W-1:0] qa_c;
  logic [W-1:0] qb_c;
  logic         busy_a_c;
  logic         busy_b_c;

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    qa_c     = '0;
    qb_c     = '0;
    busy_a_c = 1'b0;
    busy_b_c = 1'b0;
    if (RST_N) begin
      if (bus.ra_en) qa_c = wb_hits_a ? bus.wd : regs[bus.ra_addr];
      if (bus.rb_en) qb_c = wb_hits_b ? bus.wd : regs[bus.rb_addr];
      busy_a_c = pending[bus.ra_addr] && !wb_hits_a;
      busy_b_c = pending[bus.rb_addr] && !wb_hits_b;
    end
  end

  assign bus.qa     = qa_c;
  assign bus.qb     = qb_c;
  assign bus.busy_a = busy_a_c;
  assign bus.busy_b = busy_b_c;
  assign bus.stall  = (bus.ra_en && busy_a_c) || (bus.rb_en && busy_b_c);
  assign bus.sb_err = sb_err_q;
  assign bus.pc     = regs[PC_IDX];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: each cycle's expectations are queued as stimulus is
// driven, then popped and compared on the falling edge before the state-updating edge.
module tb_regfile_sb;
  localparam int W  = 16;
  localparam int AW = 3;

  typedef enum logic [2:0] {F_QA, F_QB, F_BUSY_A, F_BUSY_B, F_STALL, F_SB_ERR, F_PC} field_e;

  typedef struct {
    field_e      field;
    string       tag;
    logic [15:0] exp;
  } exp_t;

  logic CLK;
  logic RST_N;
  regfile_sb_if #(.W(W), .AW(AW)) bus ();

  regfile_sb #(.W(W), .NREG(8), .AW(AW), .PC_STEP(2), .RESET_PC(16'h0000)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] observe(input field_e f);
    case (f)
      F_QA:     return bus.qa;
      F_QB:     return bus.qb;
      F_BUSY_A: return {15'd0, bus.busy_a};
      F_BUSY_B: return {15'd0, bus.busy_b};
      F_STALL:  return {15'd0, bus.stall};
      F_SB_ERR: return {15'd0, bus.sb_err};
      default:  return bus.pc;
    endcase
  endfunction

  task automatic expect_val(input field_e f, input string tag, input logic [15:0] v);
    exp_t e;
    e.field = f;
    e.tag   = tag;
    e.exp   = v;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.we = 1'b0;  bus.waddr = '0;  bus.wd = '0;
    bus.pc_we = 1'b0;  bus.pc_d = '0;  bus.pc_inc = 1'b0;
    bus.ra_en = 1'b0;  bus.ra_addr = '0;
    bus.rb_en = 1'b0;  bus.rb_addr = '0;
    bus.sb_set = 1'b0;  bus.sb_addr = '0;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge CLK);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.field), e.exp);
    end
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wd = d;
  endtask

  task automatic rd_a(input logic [2:0] a);
    bus.ra_en = 1'b1; bus.ra_addr = a;
  endtask

  task automatic rd_b(input logic [2:0] a);
    bus.rb_en = 1'b1; bus.rb_addr = a;
  endtask

  initial begin
    idle();
    RST_N = 1'b0;
    rd_a(3'd7); rd_b(3'd7);
    expect_val(F_QA, "rst_qa_forced", 16'h0000);
    expect_val(F_QB, "rst_qb_forced", 16'h0000);
    expect_val(F_PC, "rst_pc", 16'h0000);
    tick();
    RST_N = 1'b1;

    // Preload R3, PC and a pending R5, then reset while a write is also requested.
    wr(3'd3, 16'h1234); bus.pc_we = 1'b1; bus.pc_d = 16'h0100;
    bus.sb_set = 1'b1; bus.sb_addr = 3'd5; rd_a(3'd3);
    expect_val(F_QA, "pre_bypass_r3", 16'h1234);
    tick();
    rd_a(3'd3); rd_b(3'd5);
    expect_val(F_QA, "pre_r3", 16'h1234);
    expect_val(F_BUSY_B, "pre_busy_r5", 16'd1);
    expect_val(F_STALL, "pre_stall", 16'd1);
    expect_val(F_PC, "pre_pc", 16'h0100);
    tick();
    RST_N = 1'b0;
    wr(3'd3, 16'hFFFF); bus.pc_inc = 1'b1; bus.sb_set = 1'b1; bus.sb_addr = 3'd5;
    rd_a(3'd3); rd_b(3'd5);
    expect_val(F_QA, "rst_qa_zero", 16'h0000);
    expect_val(F_BUSY_B, "rst_busy_zero", 16'd0);
    expect_val(F_STALL, "rst_stall_zero", 16'd0);
    tick();
    RST_N = 1'b1;
    rd_a(3'd3); rd_b(3'd5);
    expect_val(F_QA, "post_rst_r3", 16'h0000);
    expect_val(F_BUSY_B, "post_rst_r5_free", 16'd0);
    expect_val(F_PC, "post_rst_pc", 16'h0000);
    expect_val(F_SB_ERR, "post_rst_err", 16'd0);
    tick();

    // Bypass on both ports.
    wr(3'd2, 16'h0055);
    tick();
    wr(3'd2, 16'hAAAA); rd_a(3'd2); rd_b(3'd2);
    expect_val(F_QA, "byp_qa", 16'hAAAA);
    expect_val(F_QB, "byp_qb", 16'hAAAA);
    tick();
    rd_a(3'd2); bus.rb_addr = 3'd2;
    expect_val(F_QA, "byp_stored", 16'hAAAA);
    expect_val(F_QB, "qb_disabled", 16'h0000);
    tick();

    // Scoreboard set, stall, disabled-port masking and clear by write-back.
    bus.sb_set = 1'b1; bus.sb_addr = 3'd4; rd_a(3'd4);
    expect_val(F_BUSY_A, "sb_not_yet", 16'd0);
    tick();
    rd_a(3'd4);
    expect_val(F_BUSY_A, "sb_busy_a", 16'd1);
    expect_val(F_STALL, "sb_stall", 16'd1);
    tick();
    bus.ra_addr = 3'd4;
    expect_val(F_BUSY_A, "sb_busy_dis", 16'd1);
    expect_val(F_STALL, "sb_nostall_dis", 16'd0);
    tick();
    wr(3'd4, 16'h0F0F); rd_a(3'd4);
    expect_val(F_BUSY_A, "clr_busy_same", 16'd0);
    expect_val(F_STALL, "clr_stall_same", 16'd0);
    expect_val(F_QA, "clr_qa_same", 16'h0F0F);
    tick();
    rd_a(3'd4);
    expect_val(F_BUSY_A, "clr_busy_after", 16'd0);
    expect_val(F_QA, "clr_qa_after", 16'h0F0F);
    tick();

    // Set/clear collision, then a double set raises the sticky error.
    wr(3'd4, 16'h1111); bus.sb_set = 1'b1; bus.sb_addr = 3'd4;
    tick();
    rd_a(3'd4);
    expect_val(F_BUSY_A, "coll_set_wins", 16'd1);
    expect_val(F_QA, "coll_data", 16'h1111);
    expect_val(F_SB_ERR, "coll_no_err", 16'd0);
    tick();
    bus.sb_set = 1'b1; bus.sb_addr = 3'd4;
    expect_val(F_SB_ERR, "dbl_err_before", 16'd0);
    tick();
    rd_a(3'd4);
    expect_val(F_SB_ERR, "dbl_err", 16'd1);
    expect_val(F_BUSY_A, "dbl_still_pend", 16'd1);
    tick();
    wr(3'd4, 16'h0000);
    tick();
    rd_a(3'd4);
    expect_val(F_SB_ERR, "err_sticky", 16'd1);
    expect_val(F_BUSY_A, "err_cleared_pend", 16'd0);
    tick();

    // PC wrap, priority and absence of PC_WE/PC_INC bypass.
    bus.pc_we = 1'b1; bus.pc_d = 16'hFFFF;
    tick();
    bus.pc_inc = 1'b1; rd_a(3'd7);
    expect_val(F_PC, "pc_ffff", 16'hFFFF);
    expect_val(F_QA, "pc_read", 16'hFFFF);
    tick();
    bus.pc_we = 1'b1; bus.pc_d = 16'h0200; bus.pc_inc = 1'b1; rd_a(3'd7);
    expect_val(F_PC, "pc_wrap", 16'h0001);
    expect_val(F_QA, "pc_no_bypass", 16'h0001);
    tick();
    wr(3'd7, 16'h0300); bus.pc_we = 1'b1; bus.pc_d = 16'h0400; bus.pc_inc = 1'b1; rd_a(3'd7);
    expect_val(F_PC, "pc_we_over_inc", 16'h0200);
    expect_val(F_QA, "pc_wb_bypass", 16'h0300);
    tick();
    bus.pc_inc = 1'b1;
    expect_val(F_PC, "pc_wb_over_we", 16'h0300);
    tick();
    wr(3'd1, 16'h7777); bus.pc_inc = 1'b1;
    expect_val(F_PC, "pc_inc", 16'h0302);
    tick();
    rd_b(3'd1);
    expect_val(F_PC, "pc_inc_with_wb", 16'h0304);
    expect_val(F_QB, "wb_with_inc", 16'h7777);
    tick();

    // Fill the general registers and read them back on port B.
    for (int i = 0; i < 7; i++) begin
      wr(3'(i), 16'hC000 + 16'(i * 16'h0111));
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      rd_b(3'(i));
      expect_val(F_QB, $sformatf("fill_r%0d", i), 16'hC000 + 16'(i * 16'h0111));
      tick();
    end
    expect_val(F_SB_ERR, "err_final", 16'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with an integrated program counter, write-back bypass and per-register pending scoreboard. It is the next-generation register file for the datapath: it serves the two operand read ports and the single write-back port, and it advances the PC. It also tracks registers with outstanding results so that the sequencer can stall on read-after-write hazards instead of relying on microcode ordering.

## Interface
- W, 16, data width of every register
- NREG, 8, number of registers; index NREG-1 is the PC (minimum 2)
- AW, 3, address width; must equal clog2(NREG)
- PC_STEP, 2, amount added to the PC by PC_INC
- RESET_PC, 0, PC value after reset

- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- WE  in  1  write-back enable
- WADDR  in  AW  write-back register index
- WD  in  W  write-back data
- PC_WE  in  1  load PC from PC_D
- PC_D  in  W  PC load value
- PC_INC  in  1  PC <= PC + PC_STEP
- RA_EN  in  1  enable read port A
- RA_ADDR  in  AW  port A index
- QA  out  W  port A data, 0 when disabled
- RB_EN  in  1  enable read port B
- RB_ADDR  in  AW  port B index
- QB  out  W  port B data, 0 when disabled
- SB_SET  in  1  mark register SB_ADDR pending (result in flight)
- SB_ADDR  in  AW  scoreboard set index
- BUSY_A  out  1  RA_ADDR is pending
- BUSY_B  out  1  RB_ADDR is pending
- STALL  out  1  (RA_EN & BUSY_A) | (RB_EN & BUSY_B)
- SB_ERR  out  1  sticky: SB_SET hit an already-pending register
- PC  out  W  current PC register value

## Operation
- Storage: NREG x W registers plus NREG pending bits. The PC is register NREG-1, is readable on both ports and is writable through WE.
- Reset (RST_N low at an edge): registers 0..NREG-2 <= 0; PC <= RESET_PC; all pending bits <= 0; SB_ERR <= 0. Reset overrides every write, set and increment in that cycle.
- While RST_N is low, QA, QB, BUSY_A, BUSY_B and STALL are forced to 0.
- Write-back: WE writes WD to register WADDR and clears pending[WADDR].
- PC update priority: WE with WADDR=NREG-1, then PC_WE, then PC_INC. Only one applies per cycle.
- PC increment is modulo 2^W: the carry-out is dropped, so all-ones + 2 = 1.
- Reads are combinational. QA = reg[RA_ADDR] when RA_EN, else 0. QB likewise.
- Bypass: when WE and WADDR equals a read address in the same cycle, that port returns WD, not the stored value. This applies to the PC index as well.
- PC_WE and PC_INC are not bypassed. Reads see the old PC until the edge.
- Scoreboard: SB_SET sets pending[SB_ADDR].
- If SB_SET and a WE clear target the same register in the same cycle, the set wins and the bit remains 1.
- If SB_SET targets a register already pending and no same-cycle WE clears it, SB_ERR sets and holds until reset. The bit stays 1.
- BUSY_A = pending[RA_ADDR] & ~(WE & WADDR==RA_ADDR). The same-cycle write-back resolves the hazard through the bypass. BUSY_B is formed the same way.
- A read port whose enable is low never contributes to STALL, whatever its BUSY value.

## Timing
- Write-back and scoreboard: writes, pending set/clear, PC updates and SB_ERR take effect at the rising CLK edge; results are visible the cycle after.
- Read path: QA/QB, BUSY_A/B and STALL are zero-latency combinational from addresses, enables, WE/WADDR/WD and state.
- PC output is registered.
- After reset release: first edge with RST_N high performs normal updates; PC=RESET_PC.
- Throughput: one write-back, one SB_SET and one PC update per cycle, all independent except as stated above.

## Test plan
- Reset: load R3=0x1234, PC=0x0100, pend R5, then RST_N=0 for 1 edge -> R3=0, PC=RESET_PC, no BUSY, SB_ERR=0, QA/QB=0 during reset.
- Bypass: R2=0x0055; same cycle WE WADDR=2 WD=0xAAAA, RA_ADDR=2, RB_ADDR=2 -> QA=QB=0xAAAA; next cycle stored value is 0xAAAA.
- Scoreboard: SB_SET R4; next cycle RA_EN=1 RA_ADDR=4 -> BUSY_A=1, STALL=1.
- Scoreboard clear: WE WADDR=4 WD=0x0F0F -> BUSY_A=0, STALL=0, QA=0x0F0F the same cycle; pending[4]=0 after the edge.
- Set/clear collision and error: SB_SET R4 and WE WADDR=4 together -> R4 stays pending. A second SB_SET R4 -> SB_ERR=1 and stays high.
- PC priority and wrap: PC=0xFFFF with PC_INC -> 0x0001. PC_WE=1 PC_D=0x0200 with PC_INC -> 0x0200. WE WADDR=7 WD=0x0300 with PC_WE and PC_INC -> 0x0300.
